// File: rtl/load_ext_pkg.sv
// Shared types and helpers for the MEM-stage load sequencer.
// Load type codes, FSM encodings and split-access detection.
package load_ext_pkg;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT0 = 2'd1,
        ST_WAIT1 = 2'd2
    } state_t;

    function automatic logic type_valid(input logic [2:0] t);
        return (t == LT_LB) || (t == LT_LH) || (t == LT_LW) ||
               (t == LT_LBU) || (t == LT_LHU);
    endfunction

    // True when the access spills into the next word
    function automatic logic needs_split(input logic [2:0] t,
                                         input logic [1:0] off);
        logic s;
        s = 1'b0;
        unique case (1'b1)
            (t == LT_LH) || (t == LT_LHU): s = (off == 2'd3);
            (t == LT_LW):                  s = (off != 2'd0);
            default:                       s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/load_ext_ctrl_extend.sv
// Byte-lane select and sign/zero extension of a load result.
// Operates on the two-word little-endian byte stream {word1,word0}.
module ld_extend
    import load_ext_pkg::*;
(
    input  logic [63:0] i_stream,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_type,
    output logic [31:0] o_result
);

    logic [31:0] sel;
    logic        unused_hi;

    assign sel       = i_stream[{i_off, 3'b000} +: 32];
    assign unused_hi = ^i_stream[63:56];

    always_comb begin
        o_result = sel;
        unique case (i_type[1:0])
            2'b00:   o_result = {{24{sel[7] & ~i_type[2]}}, sel[7:0]};
            2'b01:   o_result = {{16{sel[15] & ~i_type[2]}}, sel[15:0]};
            default: o_result = sel;
        endcase
    end

endmodule

// File: rtl/load_ext_ctrl.sv
// MEM-stage load sequencer: one or two word reads, then extract/extend.
// Misaligned accesses crossing a word issue a second read at +4.
module load_ext_ctrl
    import load_ext_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_type,
    output logic        o_mem_rd,
    output logic [31:0] o_mem_addr,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_stall
);

    state_t state_q, state_d;

    logic [29:0]      wa_q, wa_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       type_q, type_d;
    logic [31:0]      word0_q, word0_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_rd_q, mem_rd_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic        req_ok;
    logic        split;
    logic        to_hit;
    logic [63:0] stream;
    logic [31:0] ext_res;

    assign req_ok = i_req & type_valid(i_type);
    assign split  = needs_split(type_q, off_q);
    assign to_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // WAIT0 extracts from the live word alone; WAIT1 merges both beats
    assign stream = (state_q == ST_WAIT1) ? {i_mem_rdata, word0_q}
                                          : {32'h0, i_mem_rdata};

    ld_extend u_ext (
        .i_stream (stream),
        .i_off    (off_q),
        .i_type   (type_q),
        .o_result (ext_res)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_ok) state_d = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (i_mem_valid) state_d = split ? ST_WAIT1 : ST_IDLE;
                else if (to_hit) state_d = ST_IDLE;
            end
            ST_WAIT1: begin
                if (i_mem_valid || to_hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wa_d       = wa_q;
        off_d      = off_q;
        type_d     = type_q;
        word0_d    = word0_q;
        cnt_d      = cnt_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_ok) begin
                    wa_d       = i_addr[31:2];
                    off_d      = i_addr[1:0];
                    type_d     = i_type;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {i_addr[31:2], 2'b00};
                end else if (i_req) begin
                    err_d = 1'b1;
                end
            end
            ST_WAIT0: begin
                if (i_mem_valid) begin
                    word0_d = i_mem_rdata;
                    if (split) begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = {wa_q + 30'd1, 2'b00};
                        cnt_d      = '0;
                    end else begin
                        data_d  = ext_res;
                        valid_d = 1'b1;
                    end
                end else if (to_hit) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT1: begin
                if (i_mem_valid) begin
                    data_d  = ext_res;
                    valid_d = 1'b1;
                end else if (to_hit) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wa_q       <= '0;
            off_q      <= '0;
            type_q     <= '0;
            word0_q    <= '0;
            cnt_q      <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wa_q       <= wa_d;
            off_q      <= off_d;
            type_q     <= type_d;
            word0_q    <= word0_d;
            cnt_q      <= cnt_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign o_mem_rd   = mem_rd_q;
    assign o_mem_addr = mem_addr_q;
    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_err      = err_q;
    assign o_stall    = (state_q != ST_IDLE) | req_ok;

endmodule
